// File: rtl/sd_host_pkg.sv
// Shared definitions for the SD host command path.
// Holds the command sequencer state encoding, the response-type encodings,
// the default response timeout and a helper that sizes the timeout counter.
package sd_host_pkg;

  // Default number of clock cycles to wait for a card response.
  localparam int TIMEOUT_CYC_DEFAULT = 64;

  // Frame handed to the serializer: {index[5:0], arg[31:0]}.
  localparam int FRAME_W = 38;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    RESP_NONE    = 2'b00,
    RESP_136     = 2'b01,
    RESP_48      = 2'b10,
    RESP_48_BUSY = 2'b11
  } resp_type_t;

  // Width of a counter that must reach cycles-1; never narrower than 1 bit.
  function automatic int ctr_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sd_cmd_sequencer_if.sv
// Link between the command sequencer and the card-side command serializer
// and response receiver.
//   master (sequencer): drives tx_valid, tx_frame, rx_en;
//                       receives tx_ready, tx_done, rx_valid, rx_data, rx_crc_err
//   slave  (phy side) : the mirror image
interface sd_cmd_sequencer_if;
  import sd_host_pkg::*;

  logic               tx_valid;
  logic               tx_ready;
  logic [FRAME_W-1:0] tx_frame;
  logic               tx_done;
  logic               rx_en;
  logic               rx_valid;
  logic [31:0]        rx_data;
  logic               rx_crc_err;

  modport master (
    output tx_valid, tx_frame, rx_en,
    input  tx_ready, tx_done, rx_valid, rx_data, rx_crc_err
  );

  modport slave (
    input  tx_valid, tx_frame, rx_en,
    output tx_ready, tx_done, rx_valid, rx_data, rx_crc_err
  );
endinterface

// File: rtl/sd_cmd_timeout_ctr.sv
// Response timeout counter for the command sequencer.
// Ports:
//   clock, reset : block clock, asynchronous active-high reset
//   clear        : synchronous clear to zero (has priority over enable)
//   enable       : count one cycle
//   expired      : counter currently equals TIMEOUT_CYC-1
// The counter saturates at all-ones so it can never wrap back into range.
module sd_cmd_timeout_ctr
  import sd_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW   = ctr_width(TIMEOUT_CYC);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]   SAT  = {CW{1'b1}};

  logic [CW-1:0] count_r;

  // Count waiting cycles; clear wins, hold once saturated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable && (count_r != SAT)) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD host command sequencer: takes a CPU command write, offers the frame to
// the command serializer, optionally waits for the card response, and keeps
// the sticky interrupt status bits.
// Ports:
//   clock, reset          : block clock, asynchronous active-high reset
//   cmd_issue             : one-cycle pulse, CPU wrote the command register
//   cmd_index/cmd_arg     : command index and argument
//   resp_type             : expected response (none / 136 / 48 / 48 busy)
//   int_clear             : write-1-clear {err_crc, err_timeout, cmd_complete}
//   link                  : serializer / receiver side (master modport)
//   cmd_inhibit           : command in flight
//   cmd_complete, err_timeout, err_crc : sticky status bits
//   resp_reg              : last latched response payload
module sd_cmd_sequencer
  import sd_host_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_issue,
  input  logic [5:0]           cmd_index,
  input  logic [31:0]          cmd_arg,
  input  logic [1:0]           resp_type,
  input  logic [2:0]           int_clear,
  sd_cmd_sequencer_if.master   link,
  output logic                 cmd_inhibit,
  output logic                 cmd_complete,
  output logic                 err_timeout,
  output logic                 err_crc,
  output logic [31:0]          resp_reg
);

  seq_state_t  state_r, state_nxt_s;
  logic        tx_valid_r, rx_en_r, inhibit_r;
  logic        tx_valid_nxt_s, rx_en_nxt_s, inhibit_nxt_s;
  logic [5:0]  index_r;
  logic [31:0] arg_r;
  resp_type_t  rtype_r;
  logic [31:0] resp_r;
  logic        timed_out_r;
  logic        cc_r, to_r, crc_r;
  logic        issue_s, resp_load_s, timeout_s, complete_s, expired_s;

  sd_cmd_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_r != ST_WAIT_RESP),
    .enable  (state_r == ST_WAIT_RESP),
    .expired (expired_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_issue) state_nxt_s = ST_SEND;
        else           state_nxt_s = ST_IDLE;
      end
      ST_SEND: begin
        if (tx_valid_r && link.tx_ready) state_nxt_s = ST_SHIFT;
        else                             state_nxt_s = ST_SEND;
      end
      ST_SHIFT: begin
        if (!link.tx_done)              state_nxt_s = ST_SHIFT;
        else if (rtype_r == RESP_NONE)  state_nxt_s = ST_DONE;
        else                            state_nxt_s = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        // A response arriving on the expiry cycle still counts as a response.
        if (link.rx_valid || expired_s) state_nxt_s = ST_DONE;
        else                            state_nxt_s = ST_WAIT_RESP;
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and event decode; handshake outputs are registered from next state.
  always_comb begin
    tx_valid_nxt_s = (state_nxt_s == ST_SEND);
    rx_en_nxt_s    = (state_nxt_s == ST_WAIT_RESP);
    inhibit_nxt_s  = (state_nxt_s != ST_IDLE);
    issue_s        = (state_r == ST_IDLE) && cmd_issue;
    resp_load_s    = (state_r == ST_WAIT_RESP) && link.rx_valid;
    timeout_s      = (state_r == ST_WAIT_RESP) && !link.rx_valid && expired_s;
    complete_s     = (state_r == ST_DONE) && !timed_out_r;
  end

  // State register and registered handshake outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_valid_r <= 1'b0;
      rx_en_r    <= 1'b0;
      inhibit_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_valid_r <= tx_valid_nxt_s;
      rx_en_r    <= rx_en_nxt_s;
      inhibit_r  <= inhibit_nxt_s;
    end
  end

  // Command fields, response payload and per-command timeout marker.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      index_r     <= 6'd0;
      arg_r       <= 32'd0;
      rtype_r     <= RESP_NONE;
      resp_r      <= 32'd0;
      timed_out_r <= 1'b0;
    end else begin
      if (issue_s) begin
        index_r <= cmd_index;
        arg_r   <= cmd_arg;
        rtype_r <= resp_type_t'(resp_type);
      end
      if (resp_load_s) begin
        resp_r <= link.rx_data;
      end
      if (issue_s) begin
        timed_out_r <= 1'b0;
      end else if (timeout_s) begin
        timed_out_r <= 1'b1;
      end
    end
  end

  // Sticky status bits: a set in the same cycle as a clear wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cc_r  <= 1'b0;
      to_r  <= 1'b0;
      crc_r <= 1'b0;
    end else begin
      cc_r  <= complete_s | (cc_r & ~int_clear[0]);
      to_r  <= timeout_s | (to_r & ~int_clear[1]);
      crc_r <= (resp_load_s & link.rx_crc_err) | (crc_r & ~int_clear[2]);
    end
  end

  assign link.tx_valid = tx_valid_r;
  assign link.tx_frame = {index_r, arg_r};
  assign link.rx_en    = rx_en_r;
  assign cmd_inhibit   = inhibit_r;
  assign cmd_complete  = cc_r;
  assign err_timeout   = to_r;
  assign err_crc       = crc_r;
  assign resp_reg      = resp_r;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer. Each command is planned up front
// as a timeline (issue, accept, tx_done, response cycles); the expected
// outputs of every cycle are derived from that timeline and from the sticky
// status rule, and compared against the DUT on the falling edge.
module tb_sd_cmd_sequencer;
  import sd_host_pkg::*;

  localparam int TO   = 64;
  localparam int MAXC = 8192;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_issue;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic [2:0]  int_clear;
  logic        cmd_inhibit, cmd_complete, err_timeout, err_crc;
  logic [31:0] resp_reg;

  sd_cmd_sequencer_if link();

  sd_cmd_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_issue    (cmd_issue),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .resp_type    (resp_type),
    .int_clear    (int_clear),
    .link         (link),
    .cmd_inhibit  (cmd_inhibit),
    .cmd_complete (cmd_complete),
    .err_timeout  (err_timeout),
    .err_crc      (err_crc),
    .resp_reg     (resp_reg)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Timeline of the command in flight (cycle numbers), plus persisting values.
  int          p_c = -100, p_a = -100, p_s = -100, p_end = -100;
  bit          p_wait = 1'b0, p_resp = 1'b0;
  logic [37:0] p_frame = 38'd0, frame_prev = 38'd0;
  logic [31:0] p_data = 32'd0, resp_prev = 32'd0;
  bit          ev_cc [MAXC];
  bit          ev_to [MAXC];
  bit          ev_crc [MAXC];
  logic        m_cc = 1'b0, m_to = 1'b0, m_crc = 1'b0;
  logic [2:0]  clr_prev = 3'b000;
  bit          chk_en = 1'b0;

  // Per-cycle comparison against the timeline model.
  always @(negedge clock) begin : cmp
    int          n;
    logic        e_cc, e_to, e_crc;
    logic [31:0] e_resp;
    logic [37:0] e_frame;
    if (chk_en) begin
      n      = cyc;
      e_cc   = ((n < MAXC) ? ev_cc[n]  : 1'b0) | (m_cc  & ~clr_prev[0]);
      e_to   = ((n < MAXC) ? ev_to[n]  : 1'b0) | (m_to  & ~clr_prev[1]);
      e_crc  = ((n < MAXC) ? ev_crc[n] : 1'b0) | (m_crc & ~clr_prev[2]);
      e_resp = (p_resp && n >= p_end) ? p_data : resp_prev;
      e_frame = (n >= p_c + 1) ? p_frame : frame_prev;
      check1("tx_valid", link.tx_valid, (n >= p_c + 1) && (n <= p_a));
      check1("cmd_inhibit", cmd_inhibit, (n >= p_c + 1) && (n <= p_end));
      check1("rx_en", link.rx_en, p_wait && (n >= p_s + 1) && (n <= p_end - 1));
      check_w("tx_frame", 64'(link.tx_frame), 64'(e_frame));
      check_w("resp_reg", 64'(resp_reg), 64'(e_resp));
      check1("cmd_complete", cmd_complete, e_cc);
      check1("err_timeout", err_timeout, e_to);
      check1("err_crc", err_crc, e_crc);
      m_cc = e_cc; m_to = e_to; m_crc = e_crc;
      clr_prev = int_clear;
    end
  end

  // Plan one command (k < 0 means no response arrives) and play it out.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input int r, input int d, input int k, input logic [31:0] data,
                         input bit crc, input bit directed, input int gap, input int stray_at,
                         input logic [2:0] clr_at_issue);
    int c, a, s, w, e;
    c = cyc;
    a = c + 1 + r;
    s = a + d;
    w = -100;
    if (typ == 2'b00)  e = s + 1;
    else if (k < 0)    e = s + 1 + TO;
    else begin w = s + 1 + k; e = w + 1; end
    resp_prev  = p_resp ? p_data : resp_prev;
    frame_prev = p_frame;
    p_c = c; p_a = a; p_s = s; p_end = e;
    p_wait  = (typ != 2'b00);
    p_resp  = (typ != 2'b00) && (k >= 0);
    p_frame = {idx, arg};
    p_data  = data;
    if (p_wait && k < 0) ev_to[e] = 1'b1;
    else                 ev_cc[e + 1] = 1'b1;
    if (p_resp && crc)   ev_crc[e] = 1'b1;
    for (int n = c; n <= e + gap; n++) begin
      cmd_issue = 1'b0;
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
      resp_type = 2'($urandom);
      if (n == c) begin
        cmd_issue = 1'b1; cmd_index = idx; cmd_arg = arg; resp_type = typ;
      end else if (n <= e && stray_at >= 0 && n == s + 1 + stray_at) begin
        cmd_issue = 1'b1; cmd_index = 6'h01;
      end else if (n <= e && !directed && $urandom_range(0, 7) == 0) begin
        cmd_issue = 1'b1;
      end
      if (n > c && n < a)  link.tx_ready = 1'b0;
      else if (n == a)     link.tx_ready = 1'b1;
      else                 link.tx_ready = directed ? 1'b0 : 1'($urandom_range(0, 1));
      if (n == s)               link.tx_done = 1'b1;
      else if (n > a && n < s)  link.tx_done = 1'b0;
      else                      link.tx_done = !directed && ($urandom_range(0, 5) == 0);
      link.rx_data    = $urandom;
      link.rx_crc_err = 1'($urandom_range(0, 1));
      if (n == w) begin
        link.rx_valid = 1'b1; link.rx_data = data; link.rx_crc_err = crc;
      end else if (p_wait && n > s && n < e) begin
        link.rx_valid = 1'b0;
      end else begin
        link.rx_valid = !directed && ($urandom_range(0, 5) == 0);
      end
      if (directed)                      int_clear = (n == c) ? clr_at_issue : 3'b000;
      else if ($urandom_range(0, 4) == 0) int_clear = 3'($urandom_range(1, 7));
      else                               int_clear = 3'b000;
      @(posedge clock); #1;
    end
    cmd_issue = 1'b0; link.tx_ready = 1'b0; link.tx_done = 1'b0;
    link.rx_valid = 1'b0; int_clear = 3'b000;
  endtask

  initial begin
    int k;
    reset = 1'b1; cmd_issue = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
    resp_type = 2'b00; int_clear = 3'b000;
    link.tx_ready = 1'b0; link.tx_done = 1'b0; link.rx_valid = 1'b0;
    link.rx_data = 32'd0; link.rx_crc_err = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check1("rst_tx_valid", link.tx_valid, 1'b0);
    check1("rst_inhibit", cmd_inhibit, 1'b0);
    check_w("rst_frame", 64'(link.tx_frame), 64'd0);
    check_w("rst_resp", 64'(resp_reg), 64'd0);
    reset = 1'b0;

    // Reset in the middle of a command (SHIFT state).
    @(posedge clock); #1;
    cmd_issue = 1'b1; cmd_index = 6'h15; cmd_arg = 32'h0BADF00D; resp_type = 2'b10;
    @(posedge clock); #1;
    cmd_issue = 1'b0; link.tx_ready = 1'b1;
    check1("send_tx_valid", link.tx_valid, 1'b1);
    check1("send_inhibit", cmd_inhibit, 1'b1);
    check_w("send_frame", 64'(link.tx_frame), 64'(38'h150BADF00D));
    @(posedge clock); #1;
    link.tx_ready = 1'b0;
    check1("shift_tx_valid", link.tx_valid, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check1("mid_rst_inhibit", cmd_inhibit, 1'b0);
    check1("mid_rst_rx_en", link.rx_en, 1'b0);
    check_w("mid_rst_frame", 64'(link.tx_frame), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk_en = 1'b1;

    // Reference command: 40-cycle shift, 48-bit response.
    run_cmd(6'h33, 32'hBEBEBEBE, 2'b10, 0, 40, 5, 32'hCAFECAF0, 1'b0, 1'b1, 0, -1, 3'b000);
    check_w("d1_frame", 64'(link.tx_frame), 64'(38'h33BEBEBEBE));
    check_w("d1_resp", 64'(resp_reg), 64'(32'hCAFECAF0));
    check1("d1_complete", cmd_complete, 1'b1);
    check1("d1_inhibit", cmd_inhibit, 1'b0);
    // No-response command.
    run_cmd(6'h0C, 32'h00000000, 2'b00, 2, 3, 0, 32'd0, 1'b0, 1'b1, 0, -1, 3'b111);
    check1("d2_complete", cmd_complete, 1'b1);
    // Timeout, with a stray second issue while waiting.
    run_cmd(6'h2A, 32'h12345678, 2'b10, 1, 2, -1, 32'd0, 1'b0, 1'b1, 0, 10, 3'b111);
    check1("d3_timeout", err_timeout, 1'b1);
    check1("d3_complete", cmd_complete, 1'b0);
    check_w("d3_frame", 64'(link.tx_frame), 64'(38'h2A12345678));
    check_w("d3_resp", 64'(resp_reg), 64'(32'hCAFECAF0));
    // CRC error then clear of err_crc and cmd_complete.
    run_cmd(6'h11, 32'hA5A5A5A5, 2'b11, 0, 1, 3, 32'hDEADBEEF, 1'b1, 1'b1, 0, -1, 3'b111);
    check1("d4_crc", err_crc, 1'b1);
    check1("d4_complete", cmd_complete, 1'b1);
    check_w("d4_resp", 64'(resp_reg), 64'(32'hDEADBEEF));
    int_clear = 3'b101;
    @(posedge clock); #1;
    int_clear = 3'b000;
    check1("d4_crc_clr", err_crc, 1'b0);
    check1("d4_complete_clr", cmd_complete, 1'b0);
    // Response on the very expiry cycle.
    run_cmd(6'h3F, 32'hFFFFFFFF, 2'b01, 0, 1, 63, 32'h13579BDF, 1'b0, 1'b1, 0, -1, 3'b111);
    check1("d5_timeout", err_timeout, 1'b0);
    check1("d5_complete", cmd_complete, 1'b1);
    check_w("d5_resp", 64'(resp_reg), 64'(32'h13579BDF));

    // Randomized commands with background noise on ignored inputs.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0:       k = -1;
        1:       k = 63;
        2:       k = 62;
        default: k = int'($urandom_range(0, 12));
      endcase
      run_cmd(6'($urandom), $urandom, 2'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 8)), k, $urandom, 1'($urandom_range(0, 1)),
              1'b0, int'($urandom_range(0, 3)), -1, 3'b000);
    end

    repeat (2) @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
